// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - pops words from a show-ahead TX FIFO and serializes them LSB-first onto txd.
// Optional parity bit is built only when UART_TX_PARITY_EN is defined.
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  enable,
  input  logic [DIV_WIDTH-1:0]  baud_div,
  input  logic                  stop2,
  input  logic                  parity_odd,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_q,
  output logic                  fifo_rd_req,
  output logic                  txd,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t                state_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DIV_WIDTH-1:0]  div_q;
  logic [DIV_WIDTH-1:0]  cnt_q;
  logic [BW-1:0]         bit_q;
  logic                  stop2_q;
  logic                  txd_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  done_d;

`ifdef UART_TX_PARITY_EN
  logic                  par_q;
`else
  logic                  unused_parity_odd;
  assign unused_parity_odd = parity_odd;
`endif

  logic                  bit_end;
  logic                  data_last;
  logic                  stop_last;
  logic                  enter_stop;
  logic [DATA_WIDTH-1:0] shift_nx;

  assign bit_end   = (cnt_q == div_q);
  assign data_last = (bit_q == BW'(DATA_WIDTH - 1));
  assign stop_last = (bit_q == BW'(stop2_q));
  assign shift_nx  = shift_q >> 1;

`ifdef UART_TX_PARITY_EN
  assign enter_stop = (state_q == S_PARITY) && bit_end;
`else
  assign enter_stop = (state_q == S_DATA) && bit_end && data_last;
`endif

  assign fifo_rd_req = rstn && (state_q == S_IDLE) && enable && !fifo_empty;

  // tx_done is registered, so predict whether the next cycle is the last stop cycle
  always_comb begin
    done_d = 1'b0;
    if (state_q == S_STOP) begin
      if (!bit_end)
        done_d = stop_last && ((cnt_q + DIV_WIDTH'(1)) == div_q);
      else if (!stop_last)
        done_d = (div_q == '0);
    end else if (enter_stop) begin
      done_d = (div_q == '0) && !stop2_q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      bit_q   <= '0;
      stop2_q <= 1'b0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      done_q <= done_d;
      case (state_q)
        S_IDLE: begin
          if (fifo_rd_req) begin
            shift_q <= fifo_q;
            div_q   <= baud_div;
            stop2_q <= stop2;
`ifdef UART_TX_PARITY_EN
            par_q   <= (^fifo_q) ^ parity_odd;
`endif
            cnt_q   <= '0;
            bit_q   <= '0;
            state_q <= S_START;
            txd_q   <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        S_START: begin
          if (bit_end) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            state_q <= S_DATA;
            txd_q   <= shift_q[0];
          end else begin
            cnt_q <= cnt_q + DIV_WIDTH'(1);
          end
        end
        S_DATA: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (data_last) begin
              bit_q <= '0;
`ifdef UART_TX_PARITY_EN
              state_q <= S_PARITY;
              txd_q   <= par_q;
`else
              state_q <= S_STOP;
              txd_q   <= 1'b1;
`endif
            end else begin
              bit_q   <= bit_q + BW'(1);
              shift_q <= shift_nx;
              txd_q   <= shift_nx[0];
            end
          end else begin
            cnt_q <= cnt_q + DIV_WIDTH'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (bit_end) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            state_q <= S_STOP;
            txd_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + DIV_WIDTH'(1);
          end
        end
`endif
        S_STOP: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (stop_last) begin
              bit_q   <= '0;
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              bit_q <= bit_q + BW'(1);
            end
          end else begin
            cnt_q <= cnt_q + DIV_WIDTH'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          txd_q   <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign txd     = txd_q;
  assign busy    = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb/tb_uart_tx_serializer.sv - directed self-checking bench for uart_tx_serializer.
// Parity vectors are included when UART_TX_PARITY_EN is defined.
module tb_uart_tx_serializer;

`ifdef UART_TX_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic        enable;
  logic [15:0] baud_div;
  logic        stop2;
  logic        parity_odd;
  logic        fifo_empty;
  logic [7:0]  fifo_q;
  logic        fifo_rd_req;
  logic        txd;
  logic        busy;
  logic        tx_done;

  always #5 clk = ~clk;

  uart_tx_serializer dut (
    .clk        (clk),
    .rstn       (rstn),
    .enable     (enable),
    .baud_div   (baud_div),
    .stop2      (stop2),
    .parity_odd (parity_odd),
    .fifo_empty (fifo_empty),
    .fifo_q     (fifo_q),
    .fifo_rd_req(fifo_rd_req),
    .txd        (txd),
    .busy       (busy),
    .tx_done    (tx_done)
  );

  int checks   = 0;
  int failures = 0;
  int bad_pops = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [7:0] fifo_mem[$];
  logic       pop_pending = 1'b0;

  task automatic fifo_upd();
    fifo_empty = (fifo_mem.size() == 0);
    fifo_q     = fifo_empty ? 8'h00 : fifo_mem[0];
  endtask

  task automatic fifo_push(input logic [7:0] d);
    fifo_mem.push_back(d);
    fifo_upd();
  endtask

  logic lt[$];
  logic lb[$];
  logic ld[$];
  logic lr[$];

  always @(negedge clk) begin
    lt.push_back(txd);
    lb.push_back(busy);
    ld.push_back(tx_done);
    lr.push_back(fifo_rd_req);
    if (fifo_rd_req && (fifo_empty || busy)) bad_pops++;
    pop_pending = fifo_rd_req;
  end

  always @(posedge clk) begin
    #1;
    if (pop_pending) begin
      pop_pending = 1'b0;
      if (fifo_mem.size() > 0) void'(fifo_mem.pop_front());
      fifo_upd();
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clear_log();
    lt.delete();
    lb.delete();
    ld.delete();
    lr.delete();
  endtask

  function automatic int find_pop(input int from);
    for (int i = from; i < lr.size(); i++)
      if (lr[i]) return i;
    return -1;
  endfunction

  function automatic int count_pops();
    int n = 0;
    for (int i = 0; i < lr.size(); i++)
      if (lr[i]) n++;
    return n;
  endfunction

  task automatic check_frame(input int p, input logic [7:0] d, input int div, input bit s2,
                             input bit podd, input string tag);
    int   per;
    int   len;
    int   b;
    int   mis;
    int   bmis;
    int   dmis;
    logic e;
    per  = div + 1;
    len  = (1 + 8 + PBITS + (s2 ? 2 : 1)) * per;
    mis  = 0;
    bmis = 0;
    dmis = 0;
    if (p < 0 || p + len + 1 >= lt.size()) begin
      check_val({tag, "_window"}, 32'd0, 32'd1);
      return;
    end
    for (int i = 0; i < len; i++) begin
      b = i / per;
      if (b == 0) e = 1'b0;
      else if (b <= 8) e = d[b-1];
      else if (PBITS == 1 && b == 9) e = (^d) ^ podd;
      else e = 1'b1;
      if (lt[p+1+i] !== e) mis++;
      if (lb[p+1+i] !== 1'b1) bmis++;
      if (ld[p+1+i] !== (i == len - 1)) dmis++;
    end
    check_val({tag, "_txd_errs"}, mis, 0);
    check_val({tag, "_busy_errs"}, bmis, 0);
    check_val({tag, "_done_errs"}, dmis, 0);
    check_val({tag, "_idle_txd"}, lt[p+1+len], 1);
    check_val({tag, "_idle_busy"}, lb[p+1+len], 0);
  endtask

  int         p1;
  int         p2;
  int         p3;
  logic [9:0] seq;

  initial begin
    rstn       = 1'b0;
    enable     = 1'b0;
    baud_div   = 16'd3;
    stop2      = 1'b0;
    parity_odd = 1'b0;
    fifo_upd();
    tick(3);
    check_val("rst_txd", txd, 1);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", tx_done, 0);
    check_val("rst_rd_req", fifo_rd_req, 0);
    enable = 1'b1;
    fifo_push(8'h55);
    #1;
    check_val("rst_no_pop_nonempty", fifo_rd_req, 0);

    // single 0x55 frame at 4 cycles per bit
    tick(1);
    clear_log();
    rstn = 1'b1;
    tick(60);
    p1 = find_pop(0);
    check_val("t1_pop_idx", p1, 0);
    check_val("t1_pops", count_pops(), 1);
    check_frame(p1, 8'h55, 3, 1'b0, 1'b0, "t1");
    seq = '0;
    for (int k = 0; k < 10; k++)
      if (p1 >= 0 && p1 + 3 + 4 * k < lt.size()) seq[k] = lt[p1 + 3 + 4 * k];
    check_val("t1_bit_sequence", seq, 10'h2AA);
    if (p1 >= 0 && p1 + 40 < ld.size()) check_val("t1_done_cycle40", ld[p1+40], 1);
    check_val("t1_idle_txd", txd, 1);

    // three back-to-back frames, two stop bits, 2 cycles per bit
    clear_log();
    baud_div = 16'd1;
    stop2    = 1'b1;
    fifo_push(8'hA5);
    fifo_push(8'h3C);
    fifo_push(8'hFF);
    tick(80);
    p1 = find_pop(0);
    p2 = (p1 < 0) ? -1 : find_pop(p1 + 1);
    p3 = (p2 < 0) ? -1 : find_pop(p2 + 1);
    check_val("t2_pops", count_pops(), 3);
    check_val("t2_gap12", p2 - p1, 23);
    check_val("t2_gap23", p3 - p2, 23);
    check_frame(p1, 8'hA5, 1, 1'b1, 1'b0, "t2a");
    check_frame(p2, 8'h3C, 1, 1'b1, 1'b0, "t2b");
    check_frame(p3, 8'hFF, 1, 1'b1, 1'b0, "t2c");

    // enable drop and divisor change mid-frame
    clear_log();
    baud_div = 16'd3;
    stop2    = 1'b0;
    fifo_push(8'h3C);
    fifo_push(8'h81);
    tick(10);
    enable   = 1'b0;
    baud_div = 16'd7;
    tick(60);
    p1 = find_pop(0);
    check_val("t3_first_pop_idx", p1, 0);
    check_val("t3_hold_pops", count_pops(), 1);
    check_frame(p1, 8'h3C, 3, 1'b0, 1'b0, "t3a");
    enable = 1'b1;
    tick(100);
    p2 = (p1 < 0) ? -1 : find_pop(p1 + 1);
    check_val("t3_resume_idx", p2, 70);
    check_frame(p2, 8'h81, 7, 1'b0, 1'b0, "t3b");

`ifdef UART_TX_PARITY_EN
    clear_log();
    baud_div   = 16'd0;
    parity_odd = 1'b0;
    fifo_push(8'h07);
    tick(20);
    p1 = find_pop(0);
    check_frame(p1, 8'h07, 0, 1'b0, 1'b0, "t4even");
    if (p1 >= 0) check_val("t4even_parity_bit", lt[p1+10], 1);
    clear_log();
    parity_odd = 1'b1;
    fifo_push(8'h07);
    tick(20);
    p1 = find_pop(0);
    check_frame(p1, 8'h07, 0, 1'b0, 1'b1, "t4odd");
    if (p1 >= 0) check_val("t4odd_parity_bit", lt[p1+10], 0);
    parity_odd = 1'b0;
`endif

    // reset during data bit 4 (0x2C has bit 4 clear)
    clear_log();
    baud_div = 16'd3;
    stop2    = 1'b0;
    fifo_push(8'h2C);
    fifo_push(8'h34);
    tick(22);
    check_val("t5_pre_busy", busy, 1);
    check_val("t5_pre_txd", txd, 0);
    rstn = 1'b0;
    #1;
    check_val("t5_rst_txd", txd, 1);
    check_val("t5_rst_busy", busy, 0);
    check_val("t5_rst_rd_req", fifo_rd_req, 0);
    check_val("t5_rst_done", tx_done, 0);
    tick(2);
    rstn = 1'b1;
    #1;
    check_val("t5_release_rd_req", fifo_rd_req, 1);
    @(posedge clk);
    #3;
    check_val("t5_start_txd", txd, 0);
    check_val("t5_start_busy", busy, 1);
    check_val("t5_fifo_drained", fifo_mem.size(), 0);
    tick(45);
    check_val("t5_final_idle_txd", txd, 1);

    check_val("no_bad_pops", bad_pops, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
